// File: rtl/add_seq_ctrl.sv
// Nibble-serial WIDTH-bit adder built around one add_4 ripple slice.
// Define SUB_EN to enable a - b (B inverted, carry forced to 1).
module add_4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [4:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < 4; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign co = c[4];
endmodule

module add_seq_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             busy
);
   localparam int NIBBLES = WIDTH / 4;
   localparam int CW      = $clog2(NIBBLES);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic             c_q;
   logic             co_q;
   logic             accept;
   logic             last;
   logic [3:0]       a_nib;
   logic [3:0]       b_nib;
   logic [3:0]       s_nib;
   logic             c_nib;

   assign accept = in_valid && in_ready;
   assign last   = (cnt == CW'(NIBBLES - 1));
   assign a_nib  = a_q[{cnt, 2'b00} +: 4];

`ifdef SUB_EN
   logic sub_q;

   assign b_nib = b_q[{cnt, 2'b00} +: 4] ^ {4{sub_q}};

   always_ff @(posedge clk) begin
      if (rst) begin
         sub_q <= 1'b0;
      end else if (accept) begin
         sub_q <= sub;
      end
   end
`else
   logic unused_sub;

   assign unused_sub = sub;
   assign b_nib      = b_q[{cnt, 2'b00} +: 4];
`endif

   add_4 u_add (
      .a  (a_nib),
      .b  (b_nib),
      .ci (c_q),
      .s  (s_nib),
      .co (c_nib)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Handshake outputs are masked during reset so nothing is offered or taken.
   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = !rst;
            if (in_valid && !rst) begin
               state_n = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) begin
               state_n = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = !rst;
            if (out_ready) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         sum_q <= '0;
         c_q   <= 1'b0;
         co_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  a_q <= a;
                  b_q <= b;
                  cnt <= '0;
`ifdef SUB_EN
                  c_q <= ci | sub;
`else
                  c_q <= ci;
`endif
               end
            end
            RUN: begin
               sum_q[{cnt, 2'b00} +: 4] <= s_nib;
               c_q <= c_nib;
               // hold on the last nibble so cnt never wraps
               if (last) begin
                  co_q <= c_nib;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign sum = sum_q;
   assign co  = co_q;
endmodule
